// File: rtl/scn_pkg.sv
// Shared types and defaults for the screen-draw scheduler.
`timescale 1ns/1ps
package scn_pkg;

  localparam int SCN_W            = 4;
  localparam int DEF_INIT_CYCLES  = 64;
  localparam int DEF_TIMEOUT      = 1048576;
  localparam int DEF_SLIDE_PERIOD = 50000000;
  localparam int DEF_CNT_W        = 26;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Wraps to the first slide when the range is inverted or the current
  // screen is at/after the end of the range or outside it.
  function automatic logic [SCN_W-1:0] next_slide(
    input logic [SCN_W-1:0] cur,
    input logic [SCN_W-1:0] first,
    input logic [SCN_W-1:0] last
  );
    if (first > last) return first;
    if (cur == last || cur < first || cur > last) return first;
    return cur + SCN_W'(1);
  endfunction

endpackage

// File: rtl/scn_draw_sched_slide_timer.sv
// Slideshow period counter, pending-advance flag and next-screen selection.
`timescale 1ns/1ps
module slide_timer
  import scn_pkg::*;
#(
  parameter int SLIDE_PERIOD = DEF_SLIDE_PERIOD,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_neg,
  input  logic             slide_en,
  input  logic [SCN_W-1:0] slide_first,
  input  logic [SCN_W-1:0] slide_last,
  input  logic [SCN_W-1:0] cur_scn,
  input  logic             grant,
  output logic             pend,
  output logic [SCN_W-1:0] next_scn
);

  logic [CNT_W-1:0] period_cnt;
  logic             wrap;

  assign wrap = (period_cnt == CNT_W'(SLIDE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      period_cnt <= '0;
      pend       <= 1'b0;
    end else if (!slide_en) begin
      period_cnt <= '0;
      pend       <= 1'b0;
    end else begin
      period_cnt <= wrap ? '0 : period_cnt + CNT_W'(1);
      // A fresh period end outranks a grant so no advance is ever lost.
      if (wrap)
        pend <= 1'b1;
      else if (grant)
        pend <= 1'b0;
    end
  end

  assign next_scn = next_slide(cur_scn, slide_first, slide_last);

endmodule

// File: rtl/scn_draw_sched.sv
// Arbitrates CPU and slideshow draw requests onto the draw_scn datapath,
// sequencing init_draw and watching done_draw with a timeout.
`timescale 1ns/1ps
module scn_draw_sched
  import scn_pkg::*;
#(
  parameter int INIT_CYCLES  = DEF_INIT_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int SLIDE_PERIOD = DEF_SLIDE_PERIOD,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_neg,
  input  logic             cpu_req,
  input  logic [SCN_W-1:0] cpu_scn,
  output logic             cpu_ack,
  input  logic             slide_en,
  input  logic [SCN_W-1:0] slide_first,
  input  logic [SCN_W-1:0] slide_last,
  output logic             busy,
  output logic [SCN_W-1:0] cur_scn,
  output logic             err,
  input  logic             err_clr,
  output logic             init_draw,
  output logic [SCN_W-1:0] opt_scn,
  input  logic             done_draw
);

  localparam int INIT_W = $clog2(INIT_CYCLES) + 1;

  state_t           state;
  logic             done_meta;
  logic             done_s;
  logic [INIT_W-1:0] init_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;
  logic             slide_pend;
  logic             slide_grant;
  logic [SCN_W-1:0] slide_scn;

  // done_draw comes from the sck domain.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      done_meta <= 1'b0;
      done_s    <= 1'b0;
    end else begin
      done_meta <= done_draw;
      done_s    <= done_meta;
    end
  end

  assign slide_grant = (state == ST_IDLE) && !cpu_req && slide_pend;
  assign to_hit      = (to_cnt == CNT_W'(TIMEOUT - 1));

  slide_timer #(
    .SLIDE_PERIOD (SLIDE_PERIOD),
    .CNT_W        (CNT_W)
  ) u_slide_timer (
    .clk         (clk),
    .rst_neg     (rst_neg),
    .slide_en    (slide_en),
    .slide_first (slide_first),
    .slide_last  (slide_last),
    .cur_scn     (cur_scn),
    .grant       (slide_grant),
    .pend        (slide_pend),
    .next_scn    (slide_scn)
  );

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state     <= ST_IDLE;
      init_draw <= 1'b0;
      opt_scn   <= '0;
      cur_scn   <= '0;
      cpu_ack   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      init_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      cpu_ack <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (err_clr)
        err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            opt_scn   <= cpu_scn;
            cpu_ack   <= 1'b1;
            busy      <= 1'b1;
            init_draw <= 1'b1;
            init_cnt  <= '0;
            state     <= ST_START;
          end else if (slide_pend) begin
            opt_scn   <= slide_scn;
            busy      <= 1'b1;
            init_draw <= 1'b1;
            init_cnt  <= '0;
            state     <= ST_START;
          end
        end

        ST_START: begin
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            init_draw <= 1'b0;
            to_cnt    <= '0;
            state     <= ST_WAIT_LOW;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end

        ST_WAIT_LOW: begin
          // The datapath may still show the previous draw's done.
          if (to_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
            if (!done_s)
              state <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (done_s) begin
            cur_scn <= opt_scn;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (to_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scn_draw_sched.sv
// Bench for scn_draw_sched: edge-level draw model compared every cycle plus
// directed scenario checks with hand-computed values.
`timescale 1ns/1ps
module tb_scn_draw_sched;

  localparam int INIT = 64;
  localparam int TO   = 5000;
  localparam int PER  = 2000;
  localparam int CW   = 26;

  logic       clk = 1'b0;
  logic       rst_neg = 1'b0;
  logic       cpu_req = 1'b0;
  logic [3:0] cpu_scn = 4'd0;
  logic       cpu_ack;
  logic       slide_en = 1'b0;
  logic [3:0] slide_first = 4'd0;
  logic [3:0] slide_last = 4'd0;
  logic       busy;
  logic [3:0] cur_scn;
  logic       err;
  logic       err_clr = 1'b0;
  logic       init_draw;
  logic [3:0] opt_scn;
  logic       done_draw = 1'b0;

  scn_draw_sched #(
    .INIT_CYCLES  (INIT),
    .TIMEOUT      (TO),
    .SLIDE_PERIOD (PER),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst_neg     (rst_neg),
    .cpu_req     (cpu_req),
    .cpu_scn     (cpu_scn),
    .cpu_ack     (cpu_ack),
    .slide_en    (slide_en),
    .slide_first (slide_first),
    .slide_last  (slide_last),
    .busy        (busy),
    .cur_scn     (cur_scn),
    .err         (err),
    .err_clr     (err_clr),
    .init_draw   (init_draw),
    .opt_scn     (opt_scn),
    .done_draw   (done_draw)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // draw_scn stand-in: done drops while init_draw is high, rises dp_delay
  // cycles after init_draw falls (never when dp_delay < 0), then holds.
  int dp_delay = 1000;
  int dp_cnt   = 0;
  bit dp_arm   = 0;
  always begin
    @(posedge clk);
    #1;
    if (init_draw) begin
      done_draw = 1'b0;
      dp_arm    = 1;
      dp_cnt    = 0;
    end else if (dp_arm) begin
      if (dp_delay >= 0 && dp_cnt == dp_delay) begin
        done_draw = 1'b1;
        dp_arm    = 0;
      end else begin
        dp_cnt++;
      end
    end
  end

  function automatic logic [3:0] exp_next(input logic [3:0] cur, input logic [3:0] f,
                                          input logic [3:0] l);
    if (f > l) return f;
    if (cur >= f && cur < l) return cur + 4'd1;
    return f;
  endfunction

  // Reference model: tracks each draw by its age in cycles since the grant.
  int         m_phase = 0;
  int         m_age = 0;
  bit         m_pend = 0, m_busy = 0, m_ack = 0, m_err = 0, m_seen_low = 0;
  bit         m_d1 = 0, m_d2 = 0;
  bit         m_wrap, m_sgrant, m_set_err;
  logic [3:0] m_opt = 4'd0, m_cur = 4'd0;

  always @(posedge clk) begin
    if (!rst_neg) begin
      m_phase = 0; m_age = 0; m_pend = 0; m_busy = 0; m_ack = 0; m_err = 0;
      m_seen_low = 0; m_d1 = 0; m_d2 = 0; m_opt = 4'd0; m_cur = 4'd0;
    end else begin
      m_wrap    = slide_en && (m_phase == PER - 1);
      m_sgrant  = 0;
      m_set_err = 0;
      m_ack     = 0;
      if (!m_busy) begin
        if (cpu_req) begin
          m_busy = 1; m_age = 0; m_opt = cpu_scn; m_ack = 1; m_seen_low = 0;
        end else if (m_pend) begin
          m_busy = 1; m_age = 0; m_opt = exp_next(m_cur, slide_first, slide_last);
          m_sgrant = 1; m_seen_low = 0;
        end
      end else begin
        m_age++;
        if (m_age > INIT) begin
          if (!m_seen_low) begin
            if (!m_d2) m_seen_low = 1;
          end else if (m_d2) begin
            m_cur  = m_opt;
            m_busy = 0;
          end
          if (m_busy && (m_age - INIT == TO)) begin
            m_set_err = 1;
            m_busy    = 0;
          end
        end
      end
      if (m_set_err) m_err = 1;
      else if (err_clr) m_err = 0;
      m_d2 = m_d1;
      m_d1 = done_draw;
      if (!slide_en) begin
        m_phase = 0;
        m_pend  = 0;
      end else begin
        m_phase = m_wrap ? 0 : m_phase + 1;
        if (m_wrap) m_pend = 1;
        else if (m_sgrant) m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_neg) begin
      check("init_draw", int'(init_draw), int'(m_busy && m_age < INIT));
      check("busy",      int'(busy),      int'(m_busy));
      check("cpu_ack",   int'(cpu_ack),   int'(m_ack));
      check("opt_scn",   int'(opt_scn),   int'(m_opt));
      check("cur_scn",   int'(cur_scn),   int'(m_cur));
      check("err",       int'(err),       int'(m_err));
    end
  end

  // Event recorder for the directed checks.
  logic       prev_busy = 0, prev_init = 0, prev_done = 0, prev_err = 0;
  logic [3:0] grants[$];
  int         grant_cyc[$];
  int         init_hi = 0, ack_cnt = 0;
  int         init_fall_cyc = 0, done_rise_cyc = 0, busy_fall_cyc = 0, err_rise_cyc = 0;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      grants.push_back(opt_scn);
      grant_cyc.push_back(cyc);
    end
    if (init_draw) init_hi++;
    if (cpu_ack) ack_cnt++;
    if (!init_draw && prev_init) init_fall_cyc = cyc;
    if (done_draw && !prev_done) done_rise_cyc = cyc;
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    if (err && !prev_err) err_rise_cyc = cyc;
    prev_busy = busy;
    prev_init = init_draw;
    prev_done = done_draw;
    prev_err  = err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_request(input logic [3:0] scn);
    int k = 0;
    cpu_scn = scn;
    cpu_req = 1'b1;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!cpu_ack && k < 20000);
    if (!cpu_ack) check("ack_wait_expired", 0, 1);
    cpu_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      tick(1);
      k++;
    end
    if (busy) check("idle_wait_expired", 1, 0);
  endtask

  task automatic wait_grants(input int n, input int bound);
    int k = 0;
    while (grants.size() < n && k < bound) begin
      tick(1);
      k++;
    end
    if (grants.size() < n) check("grant_wait_expired", grants.size(), n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_draw"}, int'(init_draw), 0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_cpu_ack"},   int'(cpu_ack),   0);
    check({tag, "_opt_scn"},   int'(opt_scn),   0);
    check({tag, "_cur_scn"},   int'(cur_scn),   0);
    check({tag, "_err"},       int'(err),       0);
  endtask

  initial begin
    int k;
    tick(3);
    check_reset_outputs("por");
    rst_neg = 1'b1;
    tick(2);

    // Slideshow 2..4 starting from screen 0.
    grants.delete(); grant_cyc.delete();
    slide_first = 4'd2; slide_last = 4'd4; slide_en = 1'b1;
    wait_grants(4, 12000);
    wait_idle(3000);
    slide_en = 1'b0;
    if (grants.size() >= 4) begin
      check("slide_0", grants[0], 2);
      check("slide_1", grants[1], 3);
      check("slide_2", grants[2], 4);
      check("slide_3", grants[3], 2);
      check("slide_gap", grant_cyc[1] - grant_cyc[0], PER);
    end
    $display("slideshow 2..4: %0d draws", grants.size());

    // CPU draw of screen 5.
    tick(3);
    grants.delete(); grant_cyc.delete();
    ack_cnt = 0; init_hi = 0;
    cpu_request(4'd5);
    wait_idle(5000);
    tick(1);
    check("cpu_ack_pulses", ack_cnt, 1);
    check("init_high_cycles", init_hi, INIT);
    check("cpu_cur_scn", int'(cur_scn), 5);
    check("busy_fall_after_done", busy_fall_cyc - done_rise_cyc, 3);
    $display("cpu draw 5: cur_scn=%0d", cur_scn);

    // CPU request and slide pend collide in one IDLE cycle.
    dp_delay = 300;
    grants.delete(); grant_cyc.delete();
    slide_first = 4'd2; slide_last = 4'd4; slide_en = 1'b1;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (m_phase != PER - 1 && k < 3 * PER);
    tick(1);
    cpu_request(4'd9);
    wait_grants(3, 6000);
    wait_idle(3000);
    slide_en = 1'b0;
    if (grants.size() >= 3) begin
      check("contend_first", grants[0], 9);
      check("contend_slide", grants[1], 2);
      check("contend_next",  grants[2], 3);
      check("contend_period", grant_cyc[2] - grant_cyc[0], PER);
    end
    $display("contention: %0d draws", grants.size());

    // Datapath never answers: timeout.
    tick(3);
    dp_delay = -1;
    cpu_request(4'd6);
    wait_idle(TO + 1000);
    tick(1);
    check("timeout_err", int'(err), 1);
    check("timeout_latency", err_rise_cyc - init_fall_cyc, TO);
    check("timeout_cur_scn", int'(cur_scn), 3);
    dp_delay = 1000;
    cpu_request(4'd8);
    wait_idle(5000);
    tick(1);
    check("after_timeout_cur_scn", int'(cur_scn), 8);
    check("err_sticky", int'(err), 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    check("err_cleared", int'(err), 0);
    $display("timeout: err cleared, cur_scn=%0d", cur_scn);

    // Reset during WAIT_DONE.
    cpu_request(4'd4);
    tick(INIT + 100);
    rst_neg = 1'b0;
    #1;
    check_reset_outputs("rst_wait_done");
    @(posedge clk);
    #1;
    rst_neg = 1'b1;
    tick(2);

    // Reset during START.
    cpu_request(4'd3);
    tick(10);
    check("start_init_high", int'(init_draw), 1);
    rst_neg = 1'b0;
    #1;
    check_reset_outputs("rst_start");
    @(posedge clk);
    #1;
    rst_neg = 1'b1;
    tick(2);
    $display("async reset: done");

    // Inverted range always targets slide_first.
    grants.delete(); grant_cyc.delete();
    slide_first = 4'd7; slide_last = 4'd3; slide_en = 1'b1;
    wait_grants(3, 8000);
    wait_idle(3000);
    slide_en = 1'b0;
    if (grants.size() >= 3) begin
      check("inv_0", grants[0], 7);
      check("inv_1", grants[1], 7);
      check("inv_2", grants[2], 7);
    end
    check("inv_cur_scn", int'(cur_scn), 7);
    $display("inverted range: %0d draws", grants.size());

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
